// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load align unit.
// Holds the RISC-V load funct3 encodings, the FSM state type and the
// access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  // Access size in bytes: 1/2/4/8 selected by funct3[1:0].
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/load_sign_ext.sv
// load_sign_ext: sign/zero extension of an already right-aligned load value.
// funct3[1:0] picks the significant width, funct3[2] selects zero extension.
module load_sign_ext #(
  parameter int N = 64
) (
  input  logic [N-1:0] shifted_i,
  input  logic [2:0]   funct3_i,
  output logic [N-1:0] ext_o
);

  int   width_bits;
  logic fill_bit;

  // Pick the significant width and the bit replicated above it.
  always_comb begin
    width_bits = N;
    fill_bit   = 1'b0;
    case (funct3_i[1:0])
      2'b00:   begin width_bits = 8;  fill_bit = shifted_i[7];   end
      2'b01:   begin width_bits = 16; fill_bit = shifted_i[15];  end
      2'b10:   begin width_bits = 32; fill_bit = shifted_i[31];  end
      default: begin width_bits = N;  fill_bit = shifted_i[N-1]; end
    endcase
    if (funct3_i[2]) begin
      fill_bit = 1'b0;
    end
  end

  // Bits above the access width take the fill bit; the rest pass through.
  for (genvar gi = 0; gi < N; gi++) begin : g_ext
    assign ext_o[gi] = (gi >= width_bits) ? fill_bit : shifted_i[gi];
  end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: turns a byte-addressed RISC-V load into one or two
// word-aligned memory reads and returns the aligned, extended result.
// Build option: define LSU_MISALIGN_EN to let misaligned loads complete
// (splitting word-crossing ones into two beats); without it any misaligned
// load returns a fault without touching memory.
module load_align_unit
  import lsu_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_funct3,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [N-1:0]  mem_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_data,
  output logic          resp_fault
);

  localparam int            BW         = N / 8;
  localparam int            OW         = $clog2(BW);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BW - 1);
  localparam logic [AW-1:0] WORD_STEP  = AW'(BW);

  lsu_state_e    state_q;
  logic [OW-1:0] off_q;
  logic [2:0]    funct3_q;
  logic [N-1:0]  beat0_q;
  logic          req_ready_q;
  logic          mem_req_valid_q;
  logic [AW-1:0] mem_addr_q;
  logic          resp_valid_q;
  logic [N-1:0]  resp_data_q;
  logic          resp_fault_q;
`ifdef LSU_MISALIGN_EN
  logic [N-1:0]  beat1_q;
  logic          cross_q;
  logic          req_cross;
`else
  logic          req_misal;
`endif

  logic [OW-1:0] req_off;
  logic [3:0]    req_size;
  logic          req_illegal;
  logic          req_fault;
  logic [N-1:0]  src0;
  logic [N-1:0]  src1;
  logic [N-1:0]  shifted;
  logic [N-1:0]  result_d;

  // Classify the offered request: illegal encoding, misalignment, word crossing.
  always_comb begin
    req_off     = req_addr[OW-1:0];
    req_size    = size_bytes(req_funct3);
    req_illegal = (req_funct3 == F3_ILLEGAL) ||
                  ((req_funct3[1:0] == F3_LD[1:0]) && (N == 32));
`ifdef LSU_MISALIGN_EN
    req_cross   = (32'(req_off) + 32'(req_size)) > 32'(BW);
    req_fault   = req_illegal;
`else
    req_misal   = (32'(req_off) & (32'(req_size) - 32'd1)) != 32'd0;
    req_fault   = req_illegal || req_misal;
`endif
  end

  // Beat sources: the incoming word is used directly in the cycle it arrives
  // so the result can be registered on the same edge that captures it.
  always_comb begin
    src0 = (state_q == WAIT0) ? mem_rdata : beat0_q;
`ifdef LSU_MISALIGN_EN
    src1 = (state_q == WAIT1) ? mem_rdata : beat1_q;
`else
    src1 = '0;
`endif
    shifted = N'({src1, src0} >> {off_q, 3'b000});
  end

  load_sign_ext #(.N(N)) u_ext (
    .shifted_i (shifted),
    .funct3_i  (funct3_q),
    .ext_o     (result_d)
  );

  // Load sequencer: state plus all registered handshake/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      off_q           <= '0;
      funct3_q        <= '0;
      beat0_q         <= '0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_fault_q    <= 1'b0;
`ifdef LSU_MISALIGN_EN
      beat1_q         <= '0;
      cross_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            off_q       <= req_off;
            funct3_q    <= req_funct3;
            beat0_q     <= '0;
`ifdef LSU_MISALIGN_EN
            beat1_q     <= '0;
            cross_q     <= req_cross;
`endif
            if (req_fault) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q         <= REQ0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= req_addr & ALIGN_MASK;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            beat0_q <= mem_rdata;
`ifdef LSU_MISALIGN_EN
            if (cross_q) begin
              state_q         <= REQ1;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= mem_addr_q + WORD_STEP;
            end else
`endif
            begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_data_q  <= result_d;
            end
          end
        end
`ifdef LSU_MISALIGN_EN
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            beat1_q      <= mem_rdata;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_data_q  <= result_d;
          end
        end
`endif
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q         <= IDLE;
          mem_req_valid_q <= 1'b0;
          resp_valid_q    <= 1'b0;
          req_ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_fault    = resp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed checks of the load align unit (N=64).
// Expectations adapt to whether LSU_MISALIGN_EN is defined for the build.
`timescale 1ns/1ps
module tb_load_align_unit;

  localparam int N  = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_funct3;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [N-1:0]  mem_rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [N-1:0]  resp_data;
  logic          resp_fault;

  load_align_unit #(.N(N), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_funct3    (req_funct3),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_fault    (resp_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Results of the most recent transaction
  logic [N-1:0]  r_data;
  logic          r_fault;
  int            r_lat;
  int            r_nreq;
  logic [AW-1:0] r_a0;
  logic [AW-1:0] r_a1;
  int            r_nresp;
  logic          r_stable;
  logic          r_anymreq;
  logic          r_timeout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Runs one load end to end: memory returns w0 then w1, one cycle after each
  // accepted read; mstall/rstall hold mem_req_ready/resp_ready low that many
  // cycles. All sampling and driving happens on the falling edge.
  task automatic do_load(input logic [AW-1:0] a, input logic [2:0] f3,
                         input logic [N-1:0] w0, input logic [N-1:0] w1,
                         input int mstall, input int rstall);
    int t;
    int ms;
    int rs;
    logic pend;
    logic seen;
    logic done;
    logic in_req;
    logic [AW-1:0] cur_a;
    logic [N-1:0] first_d;
    logic first_f;
    r_data = '0; r_fault = 1'b0; r_lat = -1; r_nreq = 0; r_a0 = '0; r_a1 = '0;
    r_nresp = 0; r_stable = 1'b1; r_anymreq = 1'b0; r_timeout = 1'b0;
    ms = mstall; rs = rstall; pend = 1'b0; seen = 1'b0; done = 1'b0; in_req = 1'b0;
    cur_a = '0; first_d = '0; first_f = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; mem_req_ready = 1'b0; resp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) r_timeout = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    while (!done && t < 60) begin
      mem_rvalid = pend;
      mem_rdata  = pend ? ((r_nreq == 1) ? w0 : w1) : '0;
      pend = 1'b0;
      if (mem_req_valid) begin
        r_anymreq = 1'b1;
        if (!in_req) begin
          in_req = 1'b1;
          cur_a  = mem_addr;
        end else if (mem_addr !== cur_a) begin
          r_stable = 1'b0;
        end
        if (ms > 0) begin
          mem_req_ready = 1'b0;
          ms--;
        end else begin
          mem_req_ready = 1'b1;
          in_req = 1'b0;
          r_nreq++;
          pend = 1'b1;
          if (r_nreq == 1) r_a0 = cur_a; else r_a1 = cur_a;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
      if (resp_valid) begin
        if (!seen) begin
          seen = 1'b1; r_lat = t; first_d = resp_data; first_f = resp_fault;
        end else if (resp_data !== first_d || resp_fault !== first_f) begin
          r_stable = 1'b0;
        end
        if (rs > 0) begin
          resp_ready = 1'b0;
          rs--;
        end else begin
          resp_ready = 1'b1;
          r_nresp++;
          done = 1'b1;
        end
      end else begin
        resp_ready = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    if (!done) r_timeout = 1'b1;
    r_data = first_d; r_fault = first_f;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_req_ready = 1'b0; resp_ready = 1'b1;
    // A few idle cycles: any further response or memory request is an error.
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) r_nresp++;
      if (mem_req_valid) r_nreq++;
      @(negedge clk);
    end
    $display("txn addr=0x%h f3=%0d data=0x%h fault=%0d lat=%0d mreqs=%0d resps=%0d",
             a, f3, r_data, r_fault, r_lat, r_nreq, r_nresp);
  endtask

  task automatic chk_txn(input string tag, input logic [N-1:0] e_data, input logic e_fault,
                         input int e_lat, input int e_nreq,
                         input logic [AW-1:0] e_a0, input logic [AW-1:0] e_a1);
    check({tag, ".timeout"}, 64'(r_timeout), 64'd0);
    check({tag, ".data"},    r_data, e_data);
    check({tag, ".fault"},   64'(r_fault), 64'(e_fault));
    check({tag, ".latency"}, 64'(r_lat), 64'(e_lat));
    check({tag, ".mem_reqs"}, 64'(r_nreq), 64'(e_nreq));
    check({tag, ".any_mreq"}, 64'(r_anymreq), 64'(e_nreq > 0));
    check({tag, ".addr0"},   r_a0, e_a0);
    check({tag, ".addr1"},   r_a1, e_a1);
    check({tag, ".resps"},   64'(r_nresp), 64'd1);
    check({tag, ".stable"},  64'(r_stable), 64'd1);
  endtask

  int bad_resp;
  int bad_mreq;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req_ready",     64'(req_ready), 64'd0);
    check("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst.resp_valid",    64'(resp_valid), 64'd0);
    check("rst.resp_fault",    64'(resp_fault), 64'd0);
    check("rst.resp_data",     resp_data, 64'd0);
    check("rst.mem_addr",      mem_addr, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready_after", 64'(req_ready), 64'd1);

    // LW / LWU from upper half of a word
    do_load(64'h1004, 3'b010, 64'h80000001_12345678, 64'h0, 0, 0);
    chk_txn("lw", 64'hFFFFFFFF_80000001, 1'b0, 3, 1, 64'h1000, 64'h0);
    do_load(64'h1004, 3'b110, 64'h80000001_12345678, 64'h0, 0, 0);
    chk_txn("lwu", 64'h00000000_80000001, 1'b0, 3, 1, 64'h1000, 64'h0);

    // LH crossing the word boundary
    do_load(64'h1007, 3'b001, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 0, 0);
`ifdef LSU_MISALIGN_EN
    chk_txn("lh_cross", 64'hFFFFFFFF_FFFFCDAB, 1'b0, 5, 2, 64'h1000, 64'h1008);
`else
    chk_txn("lh_cross", 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
`endif

    // Illegal funct3
    do_load(64'h2000, 3'b111, 64'h1111_2222_3333_4444, 64'h0, 0, 0);
    chk_txn("illegal", 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);

    // Byte and halfword extension
    do_load(64'h2003, 3'b000, 64'h0011_2233_F455_6677, 64'h0, 0, 0);
    chk_txn("lb", 64'hFFFFFFFF_FFFFFFF4, 1'b0, 3, 1, 64'h2000, 64'h0);
    do_load(64'h2003, 3'b100, 64'h0011_2233_F455_6677, 64'h0, 0, 0);
    chk_txn("lbu", 64'h00000000_000000F4, 1'b0, 3, 1, 64'h2000, 64'h0);
    do_load(64'h2006, 3'b001, 64'h8001_0000_0000_0000, 64'h0, 0, 0);
    chk_txn("lh", 64'hFFFFFFFF_FFFF8001, 1'b0, 3, 1, 64'h2000, 64'h0);
    do_load(64'h2006, 3'b101, 64'h8001_0000_0000_0000, 64'h0, 0, 0);
    chk_txn("lhu", 64'h00000000_00008001, 1'b0, 3, 1, 64'h2000, 64'h0);

    // LD with back-pressure on both the memory and response sides
    do_load(64'h3000, 3'b011, 64'hDEADBEEF_01234567, 64'h0, 3, 2);
    chk_txn("ld_stall", 64'hDEADBEEF_01234567, 1'b0, 6, 1, 64'h3000, 64'h0);

    // Misaligned but within one word, then misaligned across words
    do_load(64'h1002, 3'b010, 64'h0000_A1B2_C3D4_0000, 64'h0, 0, 0);
`ifdef LSU_MISALIGN_EN
    chk_txn("lw_mis", 64'hFFFFFFFF_A1B2C3D4, 1'b0, 3, 1, 64'h1000, 64'h0);
`else
    chk_txn("lw_mis", 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
`endif
    do_load(64'h3006, 3'b010, 64'h3344_0000_0000_0000, 64'h0000_0000_0000_1122, 0, 0);
`ifdef LSU_MISALIGN_EN
    chk_txn("lw_cross", 64'h00000000_11223344, 1'b0, 5, 2, 64'h3000, 64'h3008);
`else
    chk_txn("lw_cross", 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
`endif

    // Aligned LD at a nonzero word
    do_load(64'h4008, 3'b011, 64'h01234567_89ABCDEF, 64'h0, 0, 0);
    chk_txn("ld", 64'h01234567_89ABCDEF, 1'b0, 3, 1, 64'h4008, 64'h0);

    // Reset in the middle of a transaction, then a stray read beat
    @(negedge clk);
    check("mid.ready", 64'(req_ready), 64'd1);
    mem_req_ready = 1'b1; resp_ready = 1'b1;
`ifdef LSU_MISALIGN_EN
    req_valid = 1'b1; req_addr = 64'h5007; req_funct3 = 3'b001;
`else
    req_valid = 1'b1; req_addr = 64'h5000; req_funct3 = 3'b011;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    check("mid.req0_valid", 64'(mem_req_valid), 64'd1);
    @(negedge clk);
`ifdef LSU_MISALIGN_EN
    mem_rvalid = 1'b1; mem_rdata = 64'hAB00_0000_0000_0000;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("mid.req1_valid", 64'(mem_req_valid), 64'd1);
    check("mid.req1_addr", mem_addr, 64'h5008);
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("midrst.req_ready",     64'(req_ready), 64'd0);
    check("midrst.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("midrst.resp_valid",    64'(resp_valid), 64'd0);
    check("midrst.resp_fault",    64'(resp_fault), 64'd0);
    check("midrst.resp_data",     resp_data, 64'd0);
    check("midrst.mem_addr",      mem_addr, 64'd0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    bad_resp = 0; bad_mreq = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) bad_resp++;
      if (mem_req_valid) bad_mreq++;
      @(negedge clk);
    end
    check("midrst.no_resp", 64'(bad_resp), 64'd0);
    check("midrst.no_mreq", 64'(bad_mreq), 64'd0);
    check("midrst.ready",   64'(req_ready), 64'd1);
    $display("txn reset-abandon resp_seen=%0d mreq_seen=%0d", bad_resp, bad_mreq);

    // Unit works normally after the abandoned transaction
    do_load(64'h4001, 3'b100, 64'h0000_0000_0000_FF00, 64'h0, 0, 0);
    chk_txn("lbu_after", 64'h00000000_000000FF, 1'b0, 3, 1, 64'h4000, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  N   64  data/memory word width in bits (32 or 64)
  AW  64  address width in bits
REQ-002 Ports SHALL be, one per line (clock and reset first):
  clk          in   1    single clock; all state updates on rising edge
  rst          in   1    reset, synchronous, active-high
  req_valid    in   1    load request offered
  req_ready    out  1    unit can accept a request
  req_addr     in   AW   byte address of load
  req_funct3   in   3    RISC-V load funct3 (LB..LWU)
  mem_req_valid out 1    memory read request
  mem_req_ready in  1    memory accepts request
  mem_addr     out  AW   word-aligned read address (low log2(N/8) bits zero)
  mem_rvalid   in   1    read data valid (one pulse per accepted request)
  mem_rdata    in   N    read data word
  resp_valid   out  1    result available
  resp_ready   in   1    consumer takes result
  resp_data    out  N    aligned, extended load result
  resp_fault   out  1    result is a fault; resp_data is zero
REQ-003 Clocking SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 Access size SHALL be 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11; funct3[2]=1 SHALL zero-extend, funct3[2]=0 SHALL sign-extend, and LD SHALL pass the value unchanged.
REQ-005 funct3=111, or funct3[1:0]=11 with N=32, SHALL be illegal and produce a fault.
REQ-006 Byte offset SHALL be req_addr[log2(N/8)-1:0]; the access SHALL be misaligned when the offset is not a multiple of the size, and crossing when offset+size > N/8.
REQ-007 FSM states SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a req_valid&&req_ready handshake SHALL latch addr/funct3, then go to RESP (fault) or REQ0.
REQ-009 In REQ0/REQ1, mem_req_valid SHALL be 1 and mem_addr SHALL be the aligned base (REQ0) or base+N/8 (REQ1), held stable until mem_req_ready; the handshake SHALL move to WAIT0/WAIT1.
REQ-010 On mem_rvalid, WAIT0 SHALL capture beat0 and go to REQ1 if crossing, else RESP; WAIT1 SHALL capture beat1 and go to RESP.
REQ-011 The result SHALL be the low N bits of {beat1,beat0} >> (offset*8), extended per REQ-004; beat1 SHALL be zero when not crossing.
REQ-012 In RESP, resp_valid SHALL be 1 with resp_data/resp_fault stable until resp_ready, then return to IDLE; no new request SHALL be accepted in the same cycle.
REQ-013 Latency SHALL be as follows with zero-wait memory and resp_ready=1: single beat 3 cycles handshake-to-resp_valid, crossing 5 cycles, fault 1 cycle.
REQ-014 mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.

Reset
REQ-015 While rst=1, state SHALL go to IDLE, and req_ready, mem_req_valid, resp_valid, resp_fault, resp_data, mem_addr and the beat registers SHALL be 0.
REQ-016 rst asserted in any state, including mid-transaction, SHALL abandon the transaction; no response SHALL be issued for it.

Configuration
REQ-017 Macro LSU_MISALIGN_EN defined: misaligned accesses SHALL complete, single-beat or two-beat per REQ-006/010; only REQ-005 cases fault.
REQ-018 Macro LSU_MISALIGN_EN undefined: any misaligned access SHALL fault per REQ-008 with no memory request; REQ1/WAIT1 logic SHALL be absent.

Structure
REQ-019 Package lsu_pkg SHALL hold the load funct3 localparams, the FSM state enum, and a size_bytes(funct3) function.
REQ-020 Extension SHALL live in combinational sub-module load_sign_ext (inputs: N-bit shifted value and funct3; output: extended N-bit value), instantiated once.

Verification (N=64)
REQ-021 LW @0x1004, rdata 0x80000001_12345678 -> resp_data 0xFFFFFFFF_80000001; the same with LWU -> 0x00000000_80000001; one mem request to 0x1000.
REQ-022 With LSU_MISALIGN_EN, LH @0x1007, beat0 byte7=0xAB, beat1 byte0=0xCD -> mem_addr 0x1000 then 0x1008; resp_data 0xFFFFFFFF_FFFFCDAB.
REQ-023 Without LSU_MISALIGN_EN, LH @0x1007 -> resp_fault=1, resp_data=0, resp_valid 1 cycle after handshake, no mem_req_valid.
REQ-024 funct3=111 @0x2000 -> fault; no memory request.
REQ-025 mem_req_ready low 3 cycles and resp_ready low 2 cycles -> mem_addr and resp_data stable throughout; exactly one response.
REQ-026 rst pulsed in WAIT1, then a stray mem_rvalid -> IDLE with all outputs 0, req_ready=1 after release, no response.
